// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_t;

  localparam int unsigned N_VEC = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 4;
  localparam logic [N_VEC-1:0] EXPECTED_DEF = 8'hE8;

endpackage

// File: rtl/truth_table_sweeper_popcount8.sv
// Combinational population count of an 8-bit vector (0..8).
module popcount8 (
  input  logic [7:0] bits,
  output logic [3:0] count_c
);

  always_comb begin
    count_c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count_c = count_c + 4'(bits[i]);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a 3-input function through all 8 input vectors, captures its
// truth table and compares it against an expected table.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int unsigned      SETTLE   = 1,
  parameter logic [N_VEC-1:0] EXPECTED = EXPECTED_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic [N_VEC-1:0] table_out,
  output logic             pass,
  output logic [N_VEC-1:0] mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_VEC - 1);

  tt_state_t        state_q, state_nx;
  logic [IDX_W-1:0] idx_q, idx_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [IDX_W-1:0] abc_q, abc_nx;
  logic             busy_nx, done_nx, pass_nx;
  logic [N_VEC-1:0] table_nx, mismatch_nx;
  logic [ERR_W-1:0] err_nx;

  // Table including the bit captured this cycle, so the final compare sees bit 7.
  logic [N_VEC-1:0] table_sampled;
  logic [N_VEC-1:0] mismatch_sampled;
  logic [ERR_W-1:0] err_sampled_c;

  always_comb begin
    table_sampled        = table_out;
    table_sampled[idx_q] = y_in;
    mismatch_sampled     = table_sampled ^ EXPECTED;
  end

  popcount8 u_popcount (
    .bits    (mismatch_sampled),
    .count_c (err_sampled_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nx    = state_q;
    idx_nx      = idx_q;
    cnt_nx      = cnt_q;
    abc_nx      = abc_q;
    busy_nx     = busy;
    done_nx     = 1'b0;
    table_nx    = table_out;
    pass_nx     = pass;
    mismatch_nx = mismatch;
    err_nx      = err_cnt;

    case (state_q)
      IDLE: begin
        abc_nx = '0;
        if (start) begin
          state_nx = DRIVE;
          idx_nx   = '0;
          cnt_nx   = '0;
          table_nx = '0;
          busy_nx  = 1'b1;
        end
      end
      DRIVE: begin
        abc_nx = idx_q;
        if (cnt_q == SETTLE_LAST) begin
          state_nx = SAMPLE;
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        table_nx = table_sampled;
        if (idx_q == IDX_LAST) begin
          state_nx    = DONE;
          abc_nx      = '0;
          busy_nx     = 1'b0;
          done_nx     = 1'b1;
          pass_nx     = (mismatch_sampled == '0);
          mismatch_nx = mismatch_sampled;
          err_nx      = err_sampled_c;
        end else begin
          state_nx = DRIVE;
          idx_nx   = idx_q + IDX_W'(1);
          cnt_nx   = '0;
          abc_nx   = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
        abc_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        abc_nx   = '0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      abc_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
      pass      <= 1'b0;
      mismatch  <= '0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_nx;
      idx_q     <= idx_nx;
      cnt_q     <= cnt_nx;
      abc_q     <= abc_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      table_out <= table_nx;
      pass      <= pass_nx;
      mismatch  <= mismatch_nx;
      err_cnt   <= err_nx;
    end
  end

  assign a = abc_q[2];
  assign b = abc_q[1];
  assign c = abc_q[0];

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: two sweepers (SETTLE=1 and SETTLE=3) driven by a
// table-lookup function model, checked against a behavioural reference.
module tb_truth_table_sweeper;

  localparam logic [7:0] EXP = 8'hE8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // SETTLE = 1 instance
  logic       start1 = 1'b0;
  logic       a1, b1, c1, y1, busy1, done1, pass1;
  logic [7:0] table1, mism1, fn1 = 8'h00;
  logic [3:0] err1;
  logic [2:0] v1;
  assign v1 = {a1, b1, c1};
  assign y1 = fn1[v1];

  // SETTLE = 3 instance
  logic       start3 = 1'b0;
  logic       a3, b3, c3, y3, busy3, done3, pass3;
  logic [7:0] table3, mism3, fn3 = 8'h00;
  logic [3:0] err3;
  logic [2:0] v3;
  assign v3 = {a3, b3, c3};
  assign y3 = fn3[v3];

  truth_table_sweeper #(.SETTLE(1), .EXPECTED(EXP)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .a(a1), .b(b1), .c(c1),
    .y_in(y1), .busy(busy1), .done(done1), .table_out(table1), .pass(pass1),
    .mismatch(mism1), .err_cnt(err1)
  );

  truth_table_sweeper #(.SETTLE(3), .EXPECTED(EXP)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .a(a3), .b(b3), .c(c3),
    .y_in(y3), .busy(busy3), .done(done3), .table_out(table3), .pass(pass3),
    .mismatch(mism3), .err_cnt(err3)
  );

  // Reference function: 3-input majority, as a truth table over {a,b,c}.
  function automatic logic [7:0] majority_table();
    logic [7:0] t;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      t[i] = (int'(v[2]) + int'(v[1]) + int'(v[0])) >= 2;
    end
    return t;
  endfunction

  function automatic int ones8(input logic [7:0] x);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(x[i]);
    return n;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({a1, b1, c1} !== 3'b000) begin n_bad++; $display("FAIL reset_abc got=%b want=000", {a1, b1, c1}); end
    n_cmp++; if ({busy1, done1, pass1} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got=%b want=000", {busy1, done1, pass1}); end
    n_cmp++; if (table1 !== 8'h00) begin n_bad++; $display("FAIL reset_table got=%h want=00", table1); end
    n_cmp++; if ({mism1, err1} !== 12'h000) begin n_bad++; $display("FAIL reset_mism_err got=%h/%0d want=00/0", mism1, err1); end
    n_cmp++; if ({busy3, done3} !== 2'b00) begin n_bad++; $display("FAIL reset_dut3 got=%b want=00", {busy3, done3}); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Known-good, faulty, single-bit-error and random functions on the SETTLE=1 instance.
  task automatic test_functions();
    logic [7:0] fns[$];
    logic [7:0] m, exp_tab, exp_mism;
    int k, busy_bad;
    m = majority_table();
    fns.push_back(m);
    fns.push_back(8'h00);
    fns.push_back(~m);
    fns.push_back(m ^ 8'h80);
    for (int r = 0; r < 6; r++) fns.push_back(8'($urandom));
    foreach (fns[t]) begin
      fn1 = fns[t];
      exp_tab = 8'h00;
      for (int i = 0; i < 8; i++) exp_tab[i] = fns[t][i];
      exp_mism = exp_tab ^ EXP;
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      k = 0;
      busy_bad = 0;
      while (k <= 100 && done1 !== 1'b1) begin
        if (busy1 !== 1'b1) busy_bad++;
        @(posedge clk);
        #1;
        k++;
      end
      // done is seen 8*(SETTLE+1) edges after the start edge
      n_cmp++; if (k !== 16) begin n_bad++; $display("FAIL fn%0d_latency got=%0d want=16", t, k); end
      n_cmp++; if (busy_bad !== 0) begin n_bad++; $display("FAIL fn%0d_busy_window got=%0d lowcycles want=0", t, busy_bad); end
      n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL fn%0d_busy_at_done got=%b want=0", t, busy1); end
      n_cmp++; if (table1 !== exp_tab) begin n_bad++; $display("FAIL fn%0d_table got=%h want=%h", t, table1, exp_tab); end
      n_cmp++; if (mism1 !== exp_mism) begin n_bad++; $display("FAIL fn%0d_mismatch got=%h want=%h", t, mism1, exp_mism); end
      n_cmp++; if (err1 !== 4'(ones8(exp_mism))) begin n_bad++; $display("FAIL fn%0d_err_cnt got=%0d want=%0d", t, err1, ones8(exp_mism)); end
      n_cmp++; if (pass1 !== (exp_tab == EXP)) begin n_bad++; $display("FAIL fn%0d_pass got=%b want=%b", t, pass1, exp_tab == EXP); end
      @(posedge clk);
      #1;
      n_cmp++; if (done1 !== 1'b0 || {a1, b1, c1} !== 3'b000) begin n_bad++; $display("FAIL fn%0d_after_done got=%b/%b want=0/000", t, done1, {a1, b1, c1}); end
    end
  endtask

  task automatic test_vector_order();
    int bad;
    fn3 = majority_table();
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      if ({a3, b3, c3} !== 3'(k / 4) || done3 !== 1'b0) begin
        bad++;
        $display("FAIL order_k%0d got=%b want=%b", k, {a3, b3, c3}, 3'(k / 4));
      end
      @(posedge clk);
      #1;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL order_sequence got=%0d badcycles want=0", bad); end
    n_cmp++; if (done3 !== 1'b1 || {a3, b3, c3} !== 3'b000) begin n_bad++; $display("FAIL order_done got=%b/%b want=1/000", done3, {a3, b3, c3}); end
    n_cmp++; if (pass3 !== 1'b1 || table3 !== EXP) begin n_bad++; $display("FAIL order_result got=%b/%h want=1/%h", pass3, table3, EXP); end
    @(posedge clk);
    #1;
    n_cmp++; if (done3 !== 1'b0 || busy3 !== 1'b0 || {a3, b3, c3} !== 3'b000) begin n_bad++; $display("FAIL order_idle got=%b%b/%b want=00/000", done3, busy3, {a3, b3, c3}); end
  endtask

  task automatic test_start_while_busy();
    int dones, first_done, pass_bad, k;
    fn1 = majority_table();
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    dones = 0;
    first_done = -1;
    for (k = 0; k < 40; k++) begin
      if (k == 5) start1 = 1'b1;
      if (k == 6) start1 = 1'b0;
      if (done1 === 1'b1) begin
        dones++;
        if (first_done < 0) first_done = k;
      end
      @(posedge clk);
      #1;
    end
    n_cmp++; if (dones !== 1 || first_done !== 16) begin n_bad++; $display("FAIL busy_start_ignored got=%0d@%0d want=1@16", dones, first_done); end

    // Held start: first sweep fails, second passes; pass holds 0 until second done.
    fn1 = 8'h00;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    pass_bad = 0;
    for (k = 0; k < 34; k++) begin
      if (k == 16) begin
        n_cmp++; if (done1 !== 1'b1 || pass1 !== 1'b0) begin n_bad++; $display("FAIL held_first_done got=%b/%b want=1/0", done1, pass1); end
        fn1 = majority_table();
      end
      if (k == 17) begin
        n_cmp++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin n_bad++; $display("FAIL held_idle_gap got=%b%b want=00", busy1, done1); end
      end
      if (k == 18) begin
        n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL held_restart got=%b want=1", busy1); end
      end
      if (k > 16 && pass1 !== 1'b0) pass_bad++;
      @(posedge clk);
      #1;
    end
    start1 = 1'b0;
    n_cmp++; if (pass_bad !== 0) begin n_bad++; $display("FAIL held_pass_hold got=%0d badcycles want=0", pass_bad); end
    n_cmp++; if (done1 !== 1'b1 || pass1 !== 1'b1 || table1 !== EXP) begin n_bad++; $display("FAIL held_second_done got=%b/%b/%h want=1/1/%h", done1, pass1, table1, EXP); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int k, dones;
    fn1 = majority_table();
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    k = 0;
    while (k < 50 && {a1, b1, c1} !== 3'd4) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_cmp++; if ({a1, b1, c1} !== 3'd4) begin n_bad++; $display("FAIL rst_reach_idx4 got=%b want=100", {a1, b1, c1}); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({a1, b1, c1, busy1, done1, pass1} !== 6'b0) begin n_bad++; $display("FAIL rst_mid_flags got=%b want=000000", {a1, b1, c1, busy1, done1, pass1}); end
    n_cmp++; if ({table1, mism1, err1} !== 20'h0) begin n_bad++; $display("FAIL rst_mid_data got=%h/%h/%0d want=00/00/0", table1, mism1, err1); end
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (done1 === 1'b1) dones++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done1 === 1'b1) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL rst_no_done got=%0d want=0", dones); end
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    k = 0;
    while (k <= 100 && done1 !== 1'b1) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_cmp++; if (k !== 16 || table1 !== EXP || pass1 !== 1'b1) begin n_bad++; $display("FAIL rst_clean_sweep got=%0d/%h/%b want=16/%h/1", k, table1, pass1, EXP); end
  endtask

  initial begin
    test_reset();
    test_functions();
    test_vector_order();
    test_start_while_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
